// File: rtl/prop_settle_sequencer.sv
// Sequences one vector at a time into a combinational gate network, waits N settle cycles, then returns the vector/result pair.
// Optional glitch counting over the settle window is enabled by defining PROP_SETTLE_GLITCH_EN.
module prop_settle_sequencer #(
    parameter int IN_W           = 3,
    parameter int OUT_W          = 2,
    parameter int SETTLE_W       = 8,
    parameter int DEFAULT_SETTLE = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IN_W-1:0]     req_vec,
    input  logic [SETTLE_W-1:0] req_settle,
    output logic [IN_W-1:0]     net_in,
    input  logic [OUT_W-1:0]    net_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IN_W-1:0]     rsp_vec,
    output logic [OUT_W-1:0]    rsp_out,
    output logic                busy,
    output logic [3:0]          glitch_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [SETTLE_W-1:0] DEF_N = SETTLE_W'(DEFAULT_SETTLE);
    localparam logic [SETTLE_W-1:0] ONE_N = SETTLE_W'(1);

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]     net_in_q, net_in_d;
    logic [IN_W-1:0]     rsp_vec_q, rsp_vec_d;
    logic [OUT_W-1:0]    rsp_out_q, rsp_out_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                accept;

    // req_ready is gated by rst_n so nothing is accepted while reset is held.
    assign req_ready = rst_n && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        net_in_d    = net_in_q;
        rsp_vec_d   = rsp_vec_q;
        rsp_out_d   = rsp_out_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    net_in_d  = req_vec;
                    rsp_vec_d = req_vec;
                    cnt_d     = (req_settle == '0) ? DEF_N : req_settle;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Counter holds N-k+1 at the k-th edge after accept, so it reads 1 on the sample edge.
                if (cnt_q <= ONE_N) begin
                    cnt_d       = '0;
                    rsp_out_d   = net_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - ONE_N;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            net_in_q    <= '0;
            rsp_vec_q   <= '0;
            rsp_out_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            net_in_q    <= net_in_d;
            rsp_vec_q   <= rsp_vec_d;
            rsp_out_q   <= rsp_out_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign net_in    = net_in_q;
    assign rsp_vec   = rsp_vec_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != S_IDLE);

`ifdef PROP_SETTLE_GLITCH_EN
    logic [OUT_W-1:0] prev_q, prev_d;
    logic [3:0]       glitch_q, glitch_d;

    // The accept edge captures the reference value for the first settle-edge comparison.
    always_comb begin
        prev_d   = prev_q;
        glitch_d = glitch_q;
        if (accept) begin
            prev_d   = net_out;
            glitch_d = 4'd0;
        end else if (state_q == S_SETTLE) begin
            prev_d = net_out;
            if ((net_out != prev_q) && (glitch_q != 4'hF)) begin
                glitch_d = glitch_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            glitch_q <= 4'd0;
        end else begin
            prev_q   <= prev_d;
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = 4'd0;
`endif

endmodule
